// File: rtl/commit_event_pkg.sv
// Shared types and constants for the commit event queue: event payload,
// event kind, destination register types and CSR command encodings.
package commit_event_pkg;

  localparam int unsigned PC_MAX   = 64;
  localparam int unsigned DATA_MAX = 64;

  typedef enum logic {
    EV_INSTR = 1'b0,
    EV_CSR   = 1'b1
  } ev_kind_e;

  localparam logic [2:0] RT_GPR  = 3'd0;
  localparam logic [2:0] RT_FPR  = 3'd1;
  localparam logic [2:0] RT_VEC  = 3'd4;
  localparam logic [2:0] RT_NONE = 3'd7;

  localparam logic [2:0] CSR_WRITE = 3'd5;
  localparam logic [2:0] CSR_SET   = 3'd6;
  localparam logic [2:0] CSR_CLEAR = 3'd7;

  // pc/data held at full 64-bit width; narrower configurations zero-extend
  typedef struct packed {
    ev_kind_e              kind;
    logic [PC_MAX-1:0]     pc;
    logic [31:0]           inst;
    logic [2:0]            rtype;
    logic [4:0]            ldst;
    logic [DATA_MAX-1:0]   data;
    logic [11:0]           csr_addr;
    logic [63:0]           cycle;
    logic [63:0]           seq;
  } event_t;

  // New CSR value implied by a write/set/clear of the old value
  function automatic logic [DATA_MAX-1:0] csr_merge(input logic [2:0]          cmd,
                                                    input logic [DATA_MAX-1:0] rdata,
                                                    input logic [DATA_MAX-1:0] wdata);
    logic [DATA_MAX-1:0] res;
    res = '0;
    case (cmd)
      CSR_WRITE: res = wdata;
      CSR_SET:   res = rdata | wdata;
      CSR_CLEAR: res = rdata & ~wdata;
      default:   res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/commit_event_queue_if.sv
// Commit-side inputs and event-side outputs of the commit event queue.
interface commit_event_queue_if #(
  parameter int unsigned RETIRE_WIDTH = 3,
  parameter int unsigned ADDR_BITS    = 40,
  parameter int unsigned XLEN         = 64
);
  logic [RETIRE_WIDTH-1:0]                 cm_valid;
  logic [RETIRE_WIDTH-1:0][ADDR_BITS-1:0]  cm_pc;
  logic [RETIRE_WIDTH-1:0][31:0]           cm_inst;
  logic [RETIRE_WIDTH-1:0][2:0]            cm_rtype;
  logic [RETIRE_WIDTH-1:0][4:0]            cm_ldst;
  logic [RETIRE_WIDTH-1:0][XLEN-1:0]       cm_wdata;
  logic [2:0]                              csr_cmd;
  logic [11:0]                             csr_addr;
  logic [XLEN-1:0]                         csr_wdata;
  logic [XLEN-1:0]                         csr_rdata;

  logic                   ev_valid;
  logic                   ev_ready;
  logic                   ev_kind;
  logic [ADDR_BITS-1:0]   ev_pc;
  logic [31:0]            ev_inst;
  logic [2:0]             ev_rtype;
  logic [4:0]             ev_ldst;
  logic [XLEN-1:0]        ev_data;
  logic [11:0]            ev_csr_addr;
  logic [63:0]            ev_cycle;
  logic [63:0]            ev_seq;
  logic                   overflow;
  logic [31:0]            drop_cnt;

  modport master (
    output cm_valid, cm_pc, cm_inst, cm_rtype, cm_ldst, cm_wdata,
           csr_cmd, csr_addr, csr_wdata, csr_rdata, ev_ready,
    input  ev_valid, ev_kind, ev_pc, ev_inst, ev_rtype, ev_ldst, ev_data,
           ev_csr_addr, ev_cycle, ev_seq, overflow, drop_cnt
  );

  modport slave (
    input  cm_valid, cm_pc, cm_inst, cm_rtype, cm_ldst, cm_wdata,
           csr_cmd, csr_addr, csr_wdata, csr_rdata, ev_ready,
    output ev_valid, ev_kind, ev_pc, ev_inst, ev_rtype, ev_ldst, ev_data,
           ev_csr_addr, ev_cycle, ev_seq, overflow, drop_cnt
  );
endinterface

// File: rtl/commit_event_fifo.sv
// Circular event buffer: up to PUSH_W writes and one read per cycle, with a
// registered head entry so the consumer sees no combinational input paths.
module commit_event_fifo
  import commit_event_pkg::*;
#(
  parameter int unsigned  DEPTH  = 16,
  parameter int unsigned  PUSH_W = 4,
  localparam int unsigned NUM_W  = $clog2(PUSH_W + 1),
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_W-1:0]        push_cnt,
  input  event_t [PUSH_W-1:0]     push_data,
  input  logic                    pop,
  output logic [CNT_W-1:0]        count,
  output logic                    head_valid,
  output event_t                  head
);
  event_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_next;
  logic [CNT_W-1:0] remain, count_n;

  always_comb begin
    remain  = count - CNT_W'(pop);
    count_n = remain + CNT_W'(push_cnt);
    rd_next = rd_ptr + PTR_W'(pop);
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < int'(PUSH_W); i++) begin
      if (NUM_W'(i) < push_cnt) mem[wr_ptr + PTR_W'(i)] <= push_data[i];
    end
  end

  // Head follows the oldest surviving entry, or the first push into an empty buffer
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head       <= '0;
    end else begin
      rd_ptr     <= rd_next;
      wr_ptr     <= wr_ptr + PTR_W'(push_cnt);
      count      <= count_n;
      head_valid <= (count_n != '0);
      if (remain != '0)        head <= mem[rd_next];
      else if (push_cnt != '0) head <= push_data[0];
    end
  end

endmodule

// File: rtl/commit_event_queue.sv
// Commit trace event queue: compacts valid commit slots plus an optional CSR
// event into one batch, stamps cycle/sequence numbers, and buffers the batch.
module commit_event_queue
  import commit_event_pkg::*;
#(
  parameter int unsigned RETIRE_WIDTH = 3,
  parameter int unsigned ADDR_BITS    = 40,
  parameter int unsigned XLEN         = 64,
  parameter int unsigned DEPTH        = 16
) (
  input logic                 clock,
  input logic                 reset,
  commit_event_queue_if.slave bus
);
  localparam int unsigned PUSH_W = RETIRE_WIDTH + 1;
  localparam int unsigned NUM_W  = $clog2(PUSH_W + 1);
  localparam int unsigned IDX_W  = $clog2(PUSH_W);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  logic [63:0]          cycle_q, seq_q;
  logic                 overflow_q;
  logic [31:0]          drop_q, drop_n;
  logic [32:0]          drop_sum;
  event_t [PUSH_W-1:0]  batch;
  logic [NUM_W-1:0]     n_instr, n_ev, push_cnt;
  logic                 csr_hit, fits, pop, head_valid;
  logic [CNT_W-1:0]     count;
  event_t               head;
  logic                 unused_hi;

  // Compact valid slots in order, then append the CSR event behind them
  always_comb begin
    batch   = '0;
    n_instr = '0;
    csr_hit = bus.csr_cmd inside {CSR_WRITE, CSR_SET, CSR_CLEAR};
    for (int s = 0; s < int'(RETIRE_WIDTH); s++) begin
      if (bus.cm_valid[s]) begin
        batch[IDX_W'(n_instr)].kind  = EV_INSTR;
        batch[IDX_W'(n_instr)].pc    = PC_MAX'(bus.cm_pc[s]);
        batch[IDX_W'(n_instr)].inst  = bus.cm_inst[s];
        batch[IDX_W'(n_instr)].rtype = bus.cm_rtype[s];
        batch[IDX_W'(n_instr)].ldst  = bus.cm_ldst[s];
        batch[IDX_W'(n_instr)].data  = DATA_MAX'(bus.cm_wdata[s]);
        batch[IDX_W'(n_instr)].cycle = cycle_q;
        batch[IDX_W'(n_instr)].seq   = seq_q + 64'(n_instr);
        n_instr = n_instr + NUM_W'(1);
      end
    end
    // CSR events carry the sequence number of the most recently issued instruction
    if (csr_hit) begin
      batch[IDX_W'(n_instr)].kind     = EV_CSR;
      batch[IDX_W'(n_instr)].rtype    = RT_NONE;
      batch[IDX_W'(n_instr)].data     = csr_merge(bus.csr_cmd, DATA_MAX'(bus.csr_rdata),
                                                  DATA_MAX'(bus.csr_wdata));
      batch[IDX_W'(n_instr)].csr_addr = bus.csr_addr;
      batch[IDX_W'(n_instr)].cycle    = cycle_q;
      batch[IDX_W'(n_instr)].seq      = seq_q + 64'(n_instr) - 64'd1;
    end
    n_ev = n_instr + NUM_W'(csr_hit);
  end

  // Whole-batch admission against free space before this cycle's pop
  always_comb begin
    fits     = CNT_W'(n_ev) <= (CNT_W'(DEPTH) - count);
    push_cnt = fits ? n_ev : '0;
    pop      = head_valid & bus.ev_ready;
    drop_sum = 33'(drop_q) + 33'(n_ev);
    drop_n   = drop_sum[32] ? '1 : drop_sum[31:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_q    <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      cycle_q <= cycle_q + 64'd1;
      if (fits) begin
        seq_q <= seq_q + 64'(n_instr);
      end else begin
        overflow_q <= 1'b1;
        drop_q     <= drop_n;
      end
    end
  end

  commit_event_fifo #(
    .DEPTH  (DEPTH),
    .PUSH_W (PUSH_W)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_cnt   (push_cnt),
    .push_data  (batch),
    .pop        (pop),
    .count      (count),
    .head_valid (head_valid),
    .head       (head)
  );

  assign bus.ev_valid    = head_valid;
  assign bus.ev_kind     = head.kind;
  assign bus.ev_pc       = head.pc[ADDR_BITS-1:0];
  assign bus.ev_inst     = head.inst;
  assign bus.ev_rtype    = head.rtype;
  assign bus.ev_ldst     = head.ldst;
  assign bus.ev_data     = head.data[XLEN-1:0];
  assign bus.ev_csr_addr = head.csr_addr;
  assign bus.ev_cycle    = head.cycle;
  assign bus.ev_seq      = head.seq;
  assign bus.overflow    = overflow_q;
  assign bus.drop_cnt    = drop_q;
  // Upper pc/data bits stay zero when ADDR_BITS/XLEN are below 64
  assign unused_hi       = ^{head.pc, head.data};

endmodule
